// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: tile-loop sequencer for the conv accelerator.
// Walks output tiles (row, col, m) and input-channel tiles (n). For each n tile
// it launches the input-FM and weight loaders together, joins their done
// pulses, then launches compute. After the last n tile it launches the store.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   conv_start / conv_done    layer start pulse in / layer complete pulse out
//   busy                      high from accepted conv_start until conv_done
//   in_fm_load_start/_done    input-FM loader handshake (pulses)
//   wt_load_start/_done       weight loader handshake (pulses)
//   comp_start/_done          compute array handshake (pulses)
//   store_start/_done         output store handshake (pulses)
//   tile_base_n/m/row/col     current tile bases (CW bits each)
//   first_n / last_n          first / last input-channel tile flags
module conv_tile_scheduler #(
    parameter int CW = 16,
    parameter int N  = 32,
    parameter int Tn = 16,
    parameter int M  = 32,
    parameter int Tm = 16,
    parameter int R  = 64,
    parameter int Tr = 64,
    parameter int C  = 32,
    parameter int Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_start,
    output logic          conv_done,
    output logic          busy,
    output logic          in_fm_load_start,
    input  logic          in_fm_load_done,
    output logic          wt_load_start,
    input  logic          wt_load_done,
    output logic          comp_start,
    input  logic          comp_done,
    output logic          store_start,
    input  logic          store_done,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic          first_n,
    output logic          last_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COMP  = 3'd2,
        STORE = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Dimension and tile sizes widened by one bit so base+tile never wraps.
    localparam logic [CW:0] N_W  = (CW+1)'(N);
    localparam logic [CW:0] TN_W = (CW+1)'(Tn);
    localparam logic [CW:0] M_W  = (CW+1)'(M);
    localparam logic [CW:0] TM_W = (CW+1)'(Tm);
    localparam logic [CW:0] R_W  = (CW+1)'(R);
    localparam logic [CW:0] TR_W = (CW+1)'(Tr);
    localparam logic [CW:0] C_W  = (CW+1)'(C);
    localparam logic [CW:0] TC_W = (CW+1)'(Tc);

    // last_n value for the n==0 tile, used whenever n restarts.
    localparam logic LAST_AT_ZERO = (TN_W >= N_W);

    state_t state;

    logic in_done_l;
    logic wt_done_l;

    logic [CW:0] n_sum;
    logic [CW:0] n_sum2;
    logic [CW:0] m_sum;
    logic [CW:0] row_sum;
    logic [CW:0] col_sum;

    logic more_n;
    logic more_m;
    logic more_row;
    logic more_col;
    logic next_last;
    logic layer_last;
    logic both_done;

    assign n_sum   = {1'b0, tile_base_n} + TN_W;
    assign m_sum   = {1'b0, tile_base_m} + TM_W;
    assign row_sum = {1'b0, tile_base_row} + TR_W;
    assign col_sum = {1'b0, tile_base_col} + TC_W;

    // last_n for the n tile that follows the current one.
    assign n_sum2 = {1'b0, n_sum[CW-1:0]} + TN_W;

    assign more_n     = (n_sum < N_W);
    assign more_m     = (m_sum < M_W);
    assign more_row   = (row_sum < R_W);
    assign more_col   = (col_sum < C_W);
    assign next_last  = (n_sum2 >= N_W);
    assign layer_last = !more_m && !more_col && !more_row;

    // A done pulse arriving in the same cycle counts as already latched.
    assign both_done = (in_done_l || in_fm_load_done)
                    && (wt_done_l || wt_load_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            in_done_l        <= 1'b0;
            wt_done_l        <= 1'b0;
            conv_done        <= 1'b0;
            busy             <= 1'b0;
            in_fm_load_start <= 1'b0;
            wt_load_start    <= 1'b0;
            comp_start       <= 1'b0;
            store_start      <= 1'b0;
            tile_base_n      <= '0;
            tile_base_m      <= '0;
            tile_base_row    <= '0;
            tile_base_col    <= '0;
            first_n          <= 1'b0;
            last_n           <= 1'b0;
        end else begin
            // Start and done outputs are single-cycle pulses.
            conv_done        <= 1'b0;
            in_fm_load_start <= 1'b0;
            wt_load_start    <= 1'b0;
            comp_start       <= 1'b0;
            store_start      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (conv_start) begin
                        state            <= LOAD;
                        busy             <= 1'b1;
                        tile_base_n      <= '0;
                        tile_base_m      <= '0;
                        tile_base_row    <= '0;
                        tile_base_col    <= '0;
                        first_n          <= 1'b1;
                        last_n           <= LAST_AT_ZERO;
                        in_done_l        <= 1'b0;
                        wt_done_l        <= 1'b0;
                        in_fm_load_start <= 1'b1;
                        wt_load_start    <= 1'b1;
                    end
                end

                LOAD: begin
                    if (both_done) begin
                        state      <= COMP;
                        comp_start <= 1'b1;
                        in_done_l  <= 1'b0;
                        wt_done_l  <= 1'b0;
                    end else begin
                        if (in_fm_load_done) begin
                            in_done_l <= 1'b1;
                        end
                        if (wt_load_done) begin
                            wt_done_l <= 1'b1;
                        end
                    end
                end

                COMP: begin
                    if (comp_done) begin
                        if (more_n) begin
                            state            <= LOAD;
                            tile_base_n      <= n_sum[CW-1:0];
                            first_n          <= 1'b0;
                            last_n           <= next_last;
                            in_fm_load_start <= 1'b1;
                            wt_load_start    <= 1'b1;
                        end else begin
                            state       <= STORE;
                            store_start <= 1'b1;
                        end
                    end
                end

                STORE: begin
                    if (store_done) begin
                        tile_base_n <= '0;
                        first_n     <= 1'b1;
                        last_n      <= LAST_AT_ZERO;
                        // m advances fastest, then col, then row.
                        if (more_m) begin
                            tile_base_m <= m_sum[CW-1:0];
                        end else begin
                            tile_base_m <= '0;
                            if (more_col) begin
                                tile_base_col <= col_sum[CW-1:0];
                            end else begin
                                tile_base_col <= '0;
                                if (more_row) begin
                                    tile_base_row <= row_sum[CW-1:0];
                                end
                            end
                        end
                        if (layer_last) begin
                            state     <= FIN;
                            conv_done <= 1'b1;
                        end else begin
                            state            <= LOAD;
                            in_fm_load_start <= 1'b1;
                            wt_load_start    <= 1'b1;
                        end
                    end
                end

                FIN: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    tile_base_n   <= '0;
                    tile_base_m   <= '0;
                    tile_base_row <= '0;
                    tile_base_col <= '0;
                    first_n       <= 1'b0;
                    last_n        <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: scoreboard bench for conv_tile_scheduler.
// Expected tile sequences come from plain nested loops over the layer dims.
module tb_conv_tile_scheduler;

    localparam int PN  = 32;
    localparam int PTN = 16;
    localparam int PM  = 32;
    localparam int PTM = 16;
    localparam int PR  = 64;
    localparam int PTR = 64;
    localparam int PC  = 32;
    localparam int PTC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (default layer) ----------------
    logic a_start_m = 1'b0;
    logic a_start_s = 1'b0;
    logic a_conv_done, a_busy;
    logic a_in_start, a_wt_start, a_comp_start, a_store_start;
    logic a_in_done = 1'b0;
    logic a_wt_done = 1'b0;
    logic a_comp_r = 1'b0;
    logic a_store_r = 1'b0;
    logic a_spur_comp = 1'b0;
    logic a_spur_store = 1'b0;
    logic [15:0] a_n, a_m, a_row, a_col;
    logic a_first, a_last;

    conv_tile_scheduler #(
        .CW(16), .N(PN), .Tn(PTN), .M(PM), .Tm(PTM),
        .R(PR), .Tr(PTR), .C(PC), .Tc(PTC)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .conv_start(a_start_m | a_start_s),
        .conv_done(a_conv_done),
        .busy(a_busy),
        .in_fm_load_start(a_in_start),
        .in_fm_load_done(a_in_done),
        .wt_load_start(a_wt_start),
        .wt_load_done(a_wt_done),
        .comp_start(a_comp_start),
        .comp_done(a_comp_r | a_spur_comp),
        .store_start(a_store_start),
        .store_done(a_store_r | a_spur_store),
        .tile_base_n(a_n),
        .tile_base_m(a_m),
        .tile_base_row(a_row),
        .tile_base_col(a_col),
        .first_n(a_first),
        .last_n(a_last)
    );

    // ---------------- DUT B (single tile layer) ----------------
    logic b_start = 1'b0;
    logic b_conv_done, b_busy;
    logic b_in_start, b_wt_start, b_comp_start, b_store_start;
    logic b_in_done = 1'b0;
    logic b_wt_done = 1'b0;
    logic b_comp_done = 1'b0;
    logic b_store_done = 1'b0;
    logic [15:0] b_n, b_m, b_row, b_col;
    logic b_first, b_last;

    conv_tile_scheduler #(
        .CW(16), .N(16), .Tn(16), .M(16), .Tm(16),
        .R(64), .Tr(64), .C(16), .Tc(16)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .conv_start(b_start),
        .conv_done(b_conv_done),
        .busy(b_busy),
        .in_fm_load_start(b_in_start),
        .in_fm_load_done(b_in_done),
        .wt_load_start(b_wt_start),
        .wt_load_done(b_wt_done),
        .comp_start(b_comp_start),
        .comp_done(b_comp_done),
        .store_start(b_store_start),
        .store_done(b_store_done),
        .tile_base_n(b_n),
        .tile_base_m(b_m),
        .tile_base_row(b_row),
        .tile_base_col(b_col),
        .first_n(b_first),
        .last_n(b_last)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [65:0] tup(input int n, input int m,
                                        input int r, input int c,
                                        input bit f, input bit l);
        return {f, l, 16'(n), 16'(m), 16'(r), 16'(c)};
    endfunction

    // ---------------- scoreboard queues ----------------
    logic [65:0] lq[$];
    logic [65:0] cq[$];
    logic [65:0] sq[$];
    int dq = 0;

    int load_cnt = 0;
    int comp_cnt = 0;
    int store_cnt = 0;
    int done_cnt = 0;

    // ---------------- responder for DUT A ----------------
    int mode = 0;
    bit spur_en = 1'b0;
    int in_cnt = 0;
    int wt_cnt = 0;
    int cp_cnt = 0;
    int st_cnt = 0;
    int li = 0;
    bit in_load = 1'b0;
    longint last_in = 0;
    longint last_wt = 0;
    int join_in[3] = '{7, 2, 4};
    int join_wt[3] = '{2, 7, 4};

    function automatic int dly();
        if (mode == 0) return 3;
        return int'($urandom_range(1, 6));
    endfunction

    always @(negedge clk) begin
        a_in_done    = 1'b0;
        a_wt_done    = 1'b0;
        a_comp_r     = 1'b0;
        a_store_r    = 1'b0;
        a_spur_comp  = 1'b0;
        a_spur_store = 1'b0;
        a_start_s    = 1'b0;
        if (rst) begin
            in_cnt  = 0;
            wt_cnt  = 0;
            cp_cnt  = 0;
            st_cnt  = 0;
            li      = 0;
            in_load = 1'b0;
        end else begin
            if (in_cnt > 0) begin
                in_cnt--;
                if (in_cnt == 0) begin
                    a_in_done = 1'b1;
                    last_in   = cyc;
                end
            end
            if (wt_cnt > 0) begin
                wt_cnt--;
                if (wt_cnt == 0) begin
                    a_wt_done = 1'b1;
                    last_wt   = cyc;
                end
            end
            if (cp_cnt > 0) begin
                cp_cnt--;
                if (cp_cnt == 0) a_comp_r = 1'b1;
            end
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) a_store_r = 1'b1;
            end
            if (a_in_start) begin
                if (mode == 1 && li < 3) begin
                    in_cnt = join_in[li];
                    wt_cnt = join_wt[li];
                end else begin
                    in_cnt = dly();
                    wt_cnt = dly();
                end
                li++;
                in_load = 1'b1;
            end
            if (a_comp_start) begin
                in_load = 1'b0;
                cp_cnt  = dly();
            end
            if (a_store_start) st_cnt = dly();
            if (spur_en && in_load) begin
                case ($urandom_range(0, 5))
                    0: a_spur_comp = 1'b1;
                    1: a_spur_store = 1'b1;
                    2: a_start_s = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor for DUT A ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        longint later;
        if (!rst) begin
            if (a_in_start || a_wt_start) begin
                load_cnt++;
                chk("load_pair", {a_in_start, a_wt_start}, 2'b11);
                if (lq.size() == 0) begin
                    chk("load_extra", 1, 0);
                end else begin
                    e = lq.pop_front();
                    chk("load_tuple",
                        {a_first, a_last, a_n, a_m, a_row, a_col}, e);
                end
            end
            if (a_comp_start) begin
                comp_cnt++;
                later = (last_in > last_wt) ? last_in : last_wt;
                chk("comp_join_cycle", cyc, later + 1);
                if (cq.size() == 0) begin
                    chk("comp_extra", 1, 0);
                end else begin
                    e = cq.pop_front();
                    chk("comp_tuple",
                        {a_first, a_last, a_n, a_m, a_row, a_col}, e);
                end
            end
            if (a_store_start) begin
                store_cnt++;
                if (sq.size() == 0) begin
                    chk("store_extra", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("store_tuple",
                        {2'b00, 16'd0, a_m, a_row, a_col}, e);
                end
            end
            if (a_conv_done) begin
                done_cnt++;
                chk("busy_at_done", a_busy, 1);
                if (dq == 0) chk("done_extra", 1, 0);
                else dq--;
            end
        end
    end

    // ---------------- responder and monitor for DUT B ----------------
    int b_load_cnt = 0;
    int b_comp_cnt = 0;
    int b_store_cnt = 0;
    int b_done_cnt = 0;
    logic [65:0] b_comp_tup = '0;

    always @(negedge clk) begin
        if (rst) begin
            b_in_done    = 1'b0;
            b_wt_done    = 1'b0;
            b_comp_done  = 1'b0;
            b_store_done = 1'b0;
        end else begin
            b_in_done    = b_in_start;
            b_wt_done    = b_wt_start;
            b_comp_done  = b_comp_start;
            b_store_done = b_store_start;
            if (b_in_start && b_wt_start) b_load_cnt++;
            if (b_comp_start) begin
                b_comp_cnt++;
                b_comp_tup = {b_first, b_last, b_n, b_m, b_row, b_col};
            end
            if (b_store_start) b_store_cnt++;
            if (b_conv_done) b_done_cnt++;
        end
    end

    // ---------------- reference model and sequencing ----------------
    task automatic build();
        for (int r = 0; r < PR; r += PTR)
            for (int c = 0; c < PC; c += PTC)
                for (int m = 0; m < PM; m += PTM) begin
                    for (int n = 0; n < PN; n += PTN) begin
                        lq.push_back(tup(n, m, r, c, n == 0, n + PTN >= PN));
                        cq.push_back(tup(n, m, r, c, n == 0, n + PTN >= PN));
                    end
                    sq.push_back(tup(0, m, r, c, 1'b0, 1'b0));
                end
        dq = 1;
    endtask

    task automatic flush();
        lq.delete();
        cq.delete();
        sq.delete();
        dq = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        flush();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_a();
        @(negedge clk);
        a_start_m = 1'b1;
        @(negedge clk);
        a_start_m = 1'b0;
    endtask

    task automatic run(input int md, input bit sp);
        int d0;
        int t;
        mode = md;
        build();
        d0 = done_cnt;
        pulse_a();
        spur_en = sp;
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        spur_en = 1'b0;
        chk("done_timeout", t < 5000, 1);
        @(negedge clk);
        chk("busy_after", a_busy, 0);
        chk("queues_empty", lq.size() + cq.size() + sq.size() + dq, 0);
    endtask

    initial begin
        int l0, c0, s0, d0, t;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {a_conv_done, a_busy, a_in_start, a_wt_start, a_comp_start,
             a_store_start, a_n, a_m, a_row, a_col, a_first, a_last}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed 3-cycle responses: full tile walk and pulse counts.
        l0 = load_cnt; c0 = comp_cnt; s0 = store_cnt; d0 = done_cnt;
        run(0, 1'b0);
        chk("load_count", load_cnt - l0, 8);
        chk("comp_count", comp_cnt - c0, 8);
        chk("store_count", store_cnt - s0, 4);
        chk("done_count", done_cnt - d0, 1);

        // Load join ordering: wt first, in first, then simultaneous.
        do_reset();
        run(1, 1'b0);

        // Random latencies with spurious dones and conv_start in LOAD.
        do_reset();
        run(2, 1'b1);

        // Asynchronous reset during compute, then a clean restart.
        do_reset();
        mode = 0;
        build();
        c0 = comp_cnt;
        d0 = done_cnt;
        pulse_a();
        t = 0;
        while (comp_cnt == c0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("comp_timeout", t < 200, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mid_comp",
            {a_conv_done, a_busy, a_in_start, a_wt_start, a_comp_start,
             a_store_start, a_n, a_m, a_row, a_col, a_first, a_last}, 0);
        repeat (2) @(negedge clk);
        flush();
        rst = 1'b0;
        @(negedge clk);
        chk("no_done_on_abort", done_cnt - d0, 0);
        run(2, 1'b0);

        // Single-tile layer.
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        t = 0;
        while (b_done_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("b_timeout", t < 200, 1);
        @(negedge clk);
        chk("b_load_count", b_load_cnt, 1);
        chk("b_comp_count", b_comp_cnt, 1);
        chk("b_store_count", b_store_cnt, 1);
        chk("b_done_count", b_done_cnt, 1);
        chk("b_comp_tuple", b_comp_tup, tup(0, 0, 0, 0, 1'b1, 1'b1));
        chk("b_busy_after", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
